// File: rtl/pooling_stream_unit.sv
// Streaming KxK pooling unit (max or average, stride K) over a row-major
// pixel stream. One partial-result entry per output column is kept in a
// line buffer; a result is emitted one cycle after the last pixel of each
// window is accepted.
module pooling_stream_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int POOL_K     = 2,
   parameter int MAX_WIDTH  = 64,
   parameter int DIM_BITS   = 7
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [DIM_BITS-1:0]   cfg_width,
   input  logic [DIM_BITS-1:0]   cfg_height,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  pool_done
);

   localparam int LK   = (POOL_K == 4) ? 2 : 1;          // log2(POOL_K)
   localparam int EW   = DATA_WIDTH + 2 * LK;            // entry width, holds a full window sum
   localparam int NENT = MAX_WIDTH / POOL_K;
   localparam int IW   = (NENT > 1) ? $clog2(NENT) : 1;
   localparam logic [DIM_BITS-1:0] KDIM  = DIM_BITS'(POOL_K);
   localparam logic [DIM_BITS-1:0] KMASK = DIM_BITS'(POOL_K - 1);
   localparam logic [DIM_BITS-1:0] ONE   = DIM_BITS'(1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state_q, state_d;
   logic                  mode_q, mode_d;
   logic [DIM_BITS-1:0]   width_q, width_d, height_q, height_d;
   logic [DIM_BITS-1:0]   col_q, col_d, row_q, row_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  done_q, done_d;
   logic [EW-1:0]         lbuf_q [NENT];

   logic                  accept, in_win, first_px, last_px, row_end, frame_end;
   logic [DIM_BITS-1:0]   wlim, hlim;
   logic [IW-1:0]         idx;
   logic [EW-1:0]         entry, pix_ext, comb_val;
   logic [DATA_WIDTH-1:0] result;

   assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   // Only whole windows count; trailing columns/rows are swallowed.
   assign wlim      = width_q & ~KMASK;
   assign hlim      = height_q & ~KMASK;
   assign in_win    = (col_q < wlim) && (row_q < hlim);
   assign first_px  = ((col_q & KMASK) == '0) && ((row_q & KMASK) == '0);
   assign last_px   = ((col_q & KMASK) == KMASK) && ((row_q & KMASK) == KMASK);
   assign row_end   = (col_q == width_q - ONE);
   assign frame_end = row_end && (row_q == height_q - ONE);
   assign idx       = IW'(col_q >> LK);
   assign entry     = lbuf_q[idx];
   assign pix_ext   = EW'(in_data);

   // Merge the incoming pixel with its column entry; the first pixel of a window restarts it.
   always_comb begin
      comb_val = pix_ext;
      if (!first_px) begin
         if (mode_q) comb_val = entry + pix_ext;
         else        comb_val = (pix_ext > entry) ? pix_ext : entry;
      end
      result = mode_q ? comb_val[EW-1:2*LK] : comb_val[DATA_WIDTH-1:0];
   end

   // Line buffer of per-column partial results.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NENT; i++) lbuf_q[i] <= '0;
      end else if (accept && in_win) begin
         lbuf_q[idx] <= comb_val;
      end
   end

   // State, config, counters and output registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         width_q     <= '0;
         height_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         width_q     <= width_d;
         height_q    <= height_d;
         col_q       <= col_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   // Next-state: frame sequencing, pixel counting and result hand-off.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      width_d     = width_q;
      height_d    = height_q;
      col_d       = col_q;
      row_d       = row_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d   = mode;
               width_d  = cfg_width;
               height_d = cfg_height;
               col_d    = '0;
               row_d    = '0;
               // A frame smaller than one window finishes immediately.
               if (cfg_width >= KDIM && cfg_height >= KDIM) state_d = RUN;
               else                                         done_d  = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               if (row_end) begin
                  col_d = '0;
                  row_d = row_q + ONE;
               end else begin
                  col_d = col_q + ONE;
               end
               if (in_win && last_px) begin
                  out_valid_d = 1'b1;
                  out_data_d  = result;
               end
               if (frame_end) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (!out_valid_q || out_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != IDLE);
   assign pool_done = done_q;

endmodule

// File: tb/tb_pooling_stream_unit.sv
// Bench for pooling_stream_unit: directed vector table, hand-written
// backpressure/reset/degenerate sequences, and random frames against a
// window-arithmetic reference model. Two instances cover K=2 and K=4.
module tb_pooling_stream_unit;

   logic       clk, nrst, start2, start4, mode, in_valid, out_ready;
   logic [6:0] cfg_w, cfg_h;
   logic [7:0] in_data;
   logic       ir2, ov2, busy2, pd2, ir4, ov4, busy4, pd4;
   logic [7:0] od2, od4;
   logic       sel4;
   logic       cur_ir, cur_ov, cur_busy, cur_pd;
   logic [7:0] cur_od;

   int errors, checks, done_cnt;
   logic [7:0] got[$];
   logic [7:0] expq[$];
   logic [7:0] pixq[$];

   pooling_stream_unit #(.DATA_WIDTH(8), .POOL_K(2), .MAX_WIDTH(64), .DIM_BITS(7)) dut2 (
      .clk(clk), .nrst(nrst), .start(start2), .mode(mode), .cfg_width(cfg_w), .cfg_height(cfg_h),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir2), .out_valid(ov2), .out_data(od2),
      .out_ready(out_ready), .busy(busy2), .pool_done(pd2));

   pooling_stream_unit #(.DATA_WIDTH(8), .POOL_K(4), .MAX_WIDTH(64), .DIM_BITS(7)) dut4 (
      .clk(clk), .nrst(nrst), .start(start4), .mode(mode), .cfg_width(cfg_w), .cfg_height(cfg_h),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir4), .out_valid(ov4), .out_data(od4),
      .out_ready(out_ready), .busy(busy4), .pool_done(pd4));

   assign cur_ir   = sel4 ? ir4   : ir2;
   assign cur_ov   = sel4 ? ov4   : ov2;
   assign cur_od   = sel4 ? od4   : od2;
   assign cur_busy = sel4 ? busy4 : busy2;
   assign cur_pd   = sel4 ? pd4   : pd2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor, sampled mid-cycle when the handshake for the next edge is settled.
   always @(negedge clk) begin
      if (cur_ov && out_ready) got.push_back(cur_od);
      if (cur_pd) done_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: every complete KxK window, row-major, max or truncated mean.
   task automatic build_model(input int k, input bit md, input int w, input int h);
      expq.delete();
      for (int orow = 0; orow < h / k; orow++)
         for (int ocol = 0; ocol < w / k; ocol++) begin
            int acc;
            acc = 0;
            for (int dy = 0; dy < k; dy++)
               for (int dx = 0; dx < k; dx++) begin
                  int v;
                  v = int'(pixq[(orow * k + dy) * w + ocol * k + dx]);
                  if (md) acc += v;
                  else if (v > acc) acc = v;
               end
            if (md) acc = acc / (k * k);
            expq.push_back(8'(acc));
         end
   endtask

   task automatic start_frame(input bit k4, input bit md, input int w, input int h);
      sel4 = k4;
      got.delete();
      done_cnt = 0;
      mode  = md;
      cfg_w = 7'(w);
      cfg_h = 7'(h);
      if (k4) start4 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      start4 = 1'b0;
   endtask

   // Stream pixq into the selected unit and wait for pool_done (bounded).
   task automatic run_frame(input bit k4, input bit md, input int w, input int h, input bit rnd);
      int idx, cyc;
      start_frame(k4, md, w, h);
      idx = 0;
      cyc = 0;
      while ((idx < pixq.size() || done_cnt == 0) && cyc < 4000) begin
         in_valid  = (idx < pixq.size()) && (!rnd || $urandom_range(0, 3) != 0);
         in_data   = (idx < pixq.size()) ? pixq[idx] : 8'd0;
         out_ready = !rnd || ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (in_valid && cur_ir) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_frame(input string nm);
      chk({nm, " count"}, got.size(), expq.size());
      for (int j = 0; j < expq.size(); j++)
         if (j < got.size()) chk({nm, " data"}, got[j], expq[j]);
      chk({nm, " done"}, done_cnt, 1);
      chk({nm, " busy"}, cur_busy, 0);
   endtask

   task automatic fill_ramp(input int n);
      pixq.delete();
      for (int i = 0; i < n; i++) pixq.push_back(8'(i));
   endtask

   typedef struct packed {
      logic            k4;
      logic            md;
      logic [6:0]      w;
      logic [6:0]      h;
      logic            kind;   // 0 = ramp 0,1,2..; 1 = all 255
      logic            rnd;
      logic [2:0]      n;
      logic [3:0][7:0] e;      // e[0] is the first output
   } vec_t;

   vec_t vecs [8];

   initial begin
      int accepted, cyc, idx, oi, hold;
      logic [7:0] bp_exp[$];
      errors = 0; checks = 0; done_cnt = 0;
      nrst = 1'b0; start2 = 0; start4 = 0; mode = 0; in_valid = 0; out_ready = 1;
      cfg_w = '0; cfg_h = '0; in_data = '0; sel4 = 0;

      vecs[0] = '{1'b0, 1'b0, 7'd4, 7'd4, 1'b0, 1'b0, 3'd4, {8'd15, 8'd13, 8'd7, 8'd5}};
      vecs[1] = '{1'b0, 1'b1, 7'd4, 7'd4, 1'b0, 1'b0, 3'd4, {8'd12, 8'd10, 8'd4, 8'd2}};
      vecs[2] = '{1'b0, 1'b1, 7'd2, 7'd2, 1'b1, 1'b0, 3'd1, {8'd0, 8'd0, 8'd0, 8'd255}};
      vecs[3] = '{1'b1, 1'b1, 7'd4, 7'd4, 1'b1, 1'b0, 3'd1, {8'd0, 8'd0, 8'd0, 8'd255}};
      vecs[4] = '{1'b0, 1'b0, 7'd5, 7'd5, 1'b0, 1'b0, 3'd4, {8'd18, 8'd16, 8'd8, 8'd6}};
      vecs[5] = '{1'b0, 1'b0, 7'd4, 7'd4, 1'b0, 1'b1, 3'd4, {8'd15, 8'd13, 8'd7, 8'd5}};
      vecs[6] = '{1'b1, 1'b0, 7'd4, 7'd4, 1'b0, 1'b0, 3'd1, {8'd0, 8'd0, 8'd0, 8'd15}};
      vecs[7] = '{1'b1, 1'b1, 7'd4, 7'd4, 1'b0, 1'b0, 3'd1, {8'd0, 8'd0, 8'd0, 8'd7}};

      // Reset state
      #2;
      chk("rst out_valid", ov2, 0);
      chk("rst out_data", od2, 0);
      chk("rst in_ready", ir2, 0);
      chk("rst busy", busy2, 0);
      chk("rst pool_done", pd2, 0);
      chk("rst busy k4", busy4, 0);
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int v = 0; v < 8; v++) begin
         pixq.delete();
         for (int i = 0; i < int'(vecs[v].w) * int'(vecs[v].h); i++)
            pixq.push_back(vecs[v].kind ? 8'd255 : 8'(i));
         expq.delete();
         for (int j = 0; j < int'(vecs[v].n); j++) expq.push_back(vecs[v].e[j]);
         run_frame(vecs[v].k4, vecs[v].md, int'(vecs[v].w), int'(vecs[v].h), vecs[v].rnd);
         check_frame($sformatf("vec%0d", v));
      end

      // Backpressure: hold each pending result for 3 cycles
      bp_exp = '{8'd5, 8'd7, 8'd13, 8'd15};
      fill_ramp(16);
      start_frame(1'b0, 1'b0, 4, 4);
      idx = 0; oi = 0; hold = 0; cyc = 0;
      while (done_cnt == 0 && cyc < 2000) begin
         in_valid  = (idx < 16);
         in_data   = (idx < 16) ? 8'(idx) : 8'd0;
         out_ready = ov2 && (hold >= 3);
         @(negedge clk);
         if (in_valid && ir2) idx++;
         if (ov2) begin
            if (out_ready) begin
               hold = 0;
               oi++;
            end else begin
               chk("bp in_ready low", ir2, 0);
               chk("bp data stable", od2, (oi < 4) ? bp_exp[oi] : 8'd0);
               hold++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      expq = bp_exp;
      check_frame("bp");

      // Reset in the middle of a frame after 6 accepted pixels
      fill_ramp(16);
      start_frame(1'b0, 1'b0, 4, 4);
      accepted = 0; cyc = 0;
      while (accepted < 6 && cyc < 200) begin
         in_valid = 1'b1;
         in_data  = 8'(accepted);
         @(negedge clk);
         if (ir2) accepted++;
         @(posedge clk); #1;
         cyc++;
      end
      chk("midrst accepted", accepted, 6);
      in_valid = 1'b0;
      nrst = 1'b0;
      @(negedge clk);
      chk("midrst out_valid", ov2, 0);
      chk("midrst out_data", od2, 0);
      chk("midrst in_ready", ir2, 0);
      chk("midrst busy", busy2, 0);
      chk("midrst pool_done", pd2, 0);
      @(posedge clk); #1 nrst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst no done", done_cnt, 0);
      chk("midrst no output", got.size(), 0);
      expq = '{8'd5, 8'd7, 8'd13, 8'd15};
      run_frame(1'b0, 1'b0, 4, 4, 1'b0);
      check_frame("after rst");

      // Degenerate frame: width below the window size
      start_frame(1'b0, 1'b0, 1, 4);
      @(negedge clk);
      chk("degen pool_done", pd2, 1);
      chk("degen busy", busy2, 0);
      @(negedge clk);
      chk("degen pulse width", pd2, 0);
      chk("degen busy2", busy2, 0);
      chk("degen outputs", got.size(), 0);
      @(posedge clk); #1;

      // Random frames, random gaps and backpressure, against the model
      for (int r = 0; r < 24; r++) begin
         bit k4, md;
         int k, w, h;
         k4 = 1'($urandom_range(0, 1));
         md = 1'($urandom_range(0, 1));
         k  = k4 ? 4 : 2;
         w  = $urandom_range(k, 11);
         h  = $urandom_range(k, 11);
         pixq.delete();
         for (int i = 0; i < w * h; i++) pixq.push_back(8'($urandom_range(0, 255)));
         build_model(k, md, w, h);
         run_frame(k4, md, w, h, 1'b1);
         check_frame($sformatf("rand%0d k%0d m%0d %0dx%0d", r, k, md, w, h));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pooling_stream_unit.md
POOLING_STREAM_UNIT -- requirements
Module: pooling_stream_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, unsigned pixel width.
REQ-002 SHALL have parameter POOL_K, default 2, square window side and stride; legal values are 2 and 4 only.
REQ-003 SHALL have parameter MAX_WIDTH, default 64, maximum feature-map columns.
REQ-004 SHALL have parameter DIM_BITS, default 7, width of the dimension config ports.
REQ-005 SHALL have one clock and an asynchronous active-low reset, ports as follows.
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that latches config and begins a frame
- mode  in  1  0 = max pooling, 1 = average pooling; latched at start
- cfg_width  in  DIM_BITS  input columns per row, 1..MAX_WIDTH
- cfg_height  in  DIM_BITS  input rows per frame
- in_valid  in  1  in_data valid
- in_data  in  DATA_WIDTH  input pixel, row-major order
- in_ready  out  1  unit accepts in_data this cycle
- out_valid  out  1  out_data valid
- out_data  out  DATA_WIDTH  pooled pixel, row-major order
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in RUN and FLUSH
- pool_done  out  1  one-cycle pulse at end of frame

Function
REQ-006 SHALL use an FSM with states IDLE, RUN, FLUSH.
- IDLE -> RUN on start with cfg_width >= POOL_K and cfg_height >= POOL_K.
- IDLE -> IDLE with a pool_done pulse on start with either dimension < POOL_K.
REQ-007 SHALL transfer an input pixel only when in_valid && in_ready; in_ready SHALL be high in RUN only when (!out_valid || out_ready).
REQ-008 SHALL track column and row counters of accepted pixels; column SHALL wrap to 0 after cfg_width-1 and increment row.
REQ-009 SHALL discard pixels with column >= (cfg_width/POOL_K)*POOL_K or row >= (cfg_height/POOL_K)*POOL_K.
- Discarded pixels are still accepted (in_ready behaviour unchanged) and do not affect any output.
REQ-010 SHALL hold a line buffer of MAX_WIDTH/POOL_K partial entries, one per output column.
- Each entry is DATA_WIDTH+2*log2(POOL_K) bits wide.
- Entry is overwritten (not combined) by the first pixel of a window.
REQ-011 Combining rule for each accepted in-window pixel with its entry:
- max mode: entry := max(entry, pixel), unsigned compare.
- avg mode: entry := entry + pixel, zero-extended.
REQ-012 SHALL register the result into out_data/out_valid on the cycle after the final pixel of a window (last row and last column of window) is accepted; latency exactly 1 cycle.
- max mode: out_data = entry.
- avg mode: out_data = entry >> 2*log2(POOL_K), truncating; no overflow possible.
REQ-013 SHALL hold out_valid and out_data stable until out_ready; out_valid SHALL clear on the accepting cycle unless a new result loads in the same cycle.
REQ-014 SHALL enter FLUSH after the last pixel of the frame (row cfg_height-1, column cfg_width-1) is accepted.
- FLUSH -> IDLE when out_valid is low or being accepted.
- pool_done SHALL pulse on that transition.
REQ-015 SHALL ignore start while in RUN or FLUSH.
REQ-016 SHALL make output count per frame equal (cfg_width/POOL_K)*(cfg_height/POOL_K).

Reset
REQ-017 SHALL, while nrst is low, force state IDLE, counters 0, line buffer entries 0, and out_valid, out_data, in_ready, busy, pool_done all 0.
REQ-018 SHALL abandon a frame on reset mid-operation with no pool_done and no further output; the next start begins a clean frame.

Verification
REQ-019 Bench SHALL cover these scenarios:
- K=2, max, 4x4 frame, in_data 0..15, out_ready=1 -> outputs 5,7,13,15, then one pool_done.
- K=2, avg, same frame -> outputs 2,4,10,12.
- K=2, avg, 2x2 of 255 -> output 255; K=4, avg, 4x4 of 255 -> output 255.
- K=2, max, 5x5 frame, in_data 0..24 -> outputs 6,8,16,18; pixels of column 4 and row 4 accepted but ignored.
- Backpressure: out_ready low 3 cycles while output pending -> in_ready low, out_data stable, no data lost; sequence unchanged.
- nrst low mid-frame after 6 pixels -> all outputs 0, no pool_done; next start on a 4x4 frame yields correct 4 outputs.
- start with cfg_width=1 -> pool_done next cycle, no outputs, busy stays 0.
